// File: rtl/floating_divide_pkg.sv
// rtl/floating_divide_pkg.sv - binary32 field widths, canonical encodings and unpacked-float type
//
// Shared by floating_divide and fp_mant_div.
//   EXP_W / FRAC_W / BIAS : IEEE-754 single-precision field geometry
//   FP_NAN / FP_INF       : canonical quiet NaN and positive infinity
//   fp_t                  : {sign, exp, frac} view of a 32-bit word
package floating_divide_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS   = 127;

    localparam logic [31:0] FP_NAN = 32'h7FC0_0000;
    localparam logic [31:0] FP_INF = 32'h7F80_0000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp_t;

endpackage

// File: rtl/fp_mant_div.sv
// rtl/fp_mant_div.sv - combinational 24-bit restoring mantissa divider
//
// Ports:
//   dividend [23:0] : normalized dividend mantissa (hidden 1 set)
//   divisor  [23:0] : normalized divisor mantissa (hidden 1 set)
//   quotient [25:0] : floor(dividend * 2^25 / divisor)
//   sticky          : 1 when the division leaves a nonzero remainder
//
// Both inputs lie in [2^23, 2^24), so the ratio is in (0.5, 2) and the
// scaled quotient always fits in 26 bits. Starting the partial remainder at
// the dividend itself (rather than shifting in 25 zero bits first) skips the
// iterations that could only ever produce leading zeros.
module fp_mant_div
    import floating_divide_pkg::*;
(
    input  logic [FRAC_W:0]   dividend,
    input  logic [FRAC_W:0]   divisor,
    output logic [FRAC_W+2:0] quotient,
    output logic              sticky
);

    logic [FRAC_W+1:0] rem;

    always_comb begin
        quotient = '0;
        rem      = {1'b0, dividend};
        for (int i = FRAC_W + 2; i >= 0; i--) begin
            if (rem >= {1'b0, divisor}) begin
                quotient[i] = 1'b1;
                rem         = rem - {1'b0, divisor};
            end
            // rem < divisor < 2^24 here, so the shift never drops a bit.
            rem = rem << 1;
        end
        sticky = (rem != '0);
    end

endmodule

// File: rtl/floating_divide.sv
// rtl/floating_divide.sv - single-cycle registered IEEE-754 binary32 divider
//
// Ports:
//   a     [31:0] : dividend, binary32
//   b     [31:0] : divisor, binary32
//   value [31:0] : registered quotient a/b (RNE, denormals flushed)
//   debug [31:0] : registered raw 26-bit divider output, 0 for special cases
//   clk          : rising-edge clock
//   rst_n        : synchronous active-low reset, clears value and debug
module floating_divide
    import floating_divide_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] value,
    output logic [31:0] debug,
    input  logic        clk,
    input  logic        rst_n
);

    fp_t fa;
    fp_t fb;
    assign fa = a;
    assign fb = b;

    logic a_nan, a_inf, a_zero;
    logic b_nan, b_inf, b_zero;

    // exp==0 covers both true zero and denormals, which are treated as zero.
    assign a_nan  = (fa.exp == '1) && (fa.frac != '0);
    assign a_inf  = (fa.exp == '1) && (fa.frac == '0);
    assign a_zero = (fa.exp == '0);
    assign b_nan  = (fb.exp == '1) && (fb.frac != '0);
    assign b_inf  = (fb.exp == '1) && (fb.frac == '0);
    assign b_zero = (fb.exp == '0);

    logic [FRAC_W+2:0] quo;
    logic              quo_sticky;

    fp_mant_div u_mant_div (
        .dividend ({1'b1, fa.frac}),
        .divisor  ({1'b1, fb.frac}),
        .quotient (quo),
        .sticky   (quo_sticky)
    );

    logic              sign;
    logic [FRAC_W:0]   mant;
    logic              guard;
    logic              rest;
    logic              exp_adj;
    logic              round_up;
    logic [FRAC_W+1:0] mant_r;
    logic              carry;
    logic [FRAC_W-1:0] frac_r;
    logic signed [9:0] exp_s;
    logic [31:0]       norm_value;
    logic [31:0]       value_d, value_q;
    logic [31:0]       debug_d, debug_q;

    always_comb begin
        sign = fa.sign ^ fb.sign;

        // quo[25] set means ma >= mb: the quotient is already in [1,2).
        // Otherwise shift left one place and take one off the exponent.
        if (quo[FRAC_W+2]) begin
            mant    = quo[FRAC_W+2:2];
            guard   = quo[1];
            rest    = quo[0] | quo_sticky;
            exp_adj = 1'b0;
        end else begin
            mant    = quo[FRAC_W+1:1];
            guard   = quo[0];
            rest    = quo_sticky;
            exp_adj = 1'b1;
        end

        // Round to nearest, ties to even.
        round_up = guard & (rest | mant[0]);
        mant_r   = {1'b0, mant} + {{(FRAC_W+1){1'b0}}, round_up};
        carry    = mant_r[FRAC_W+1];
        frac_r   = carry ? mant_r[FRAC_W:1] : mant_r[FRAC_W-1:0];

        exp_s = $signed({2'b00, fa.exp}) - $signed({2'b00, fb.exp})
              + 10'(BIAS)
              - $signed({9'd0, exp_adj})
              + $signed({9'd0, carry});

        if (exp_s <= 10'sd0) begin
            norm_value = {sign, 31'd0};
        end else if (exp_s >= 10'sd255) begin
            norm_value = FP_INF | {sign, 31'd0};
        end else begin
            norm_value = {sign, exp_s[EXP_W-1:0], frac_r};
        end

        value_d = norm_value;
        debug_d = {6'd0, quo};

        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            value_d = FP_NAN;
            debug_d = '0;
        end else if (a_inf) begin
            value_d = FP_INF | {sign, 31'd0};
            debug_d = '0;
        end else if (b_inf) begin
            value_d = {sign, 31'd0};
            debug_d = '0;
        end else if (b_zero) begin
            value_d = FP_INF | {sign, 31'd0};
            debug_d = '0;
        end else if (a_zero) begin
            value_d = {sign, 31'd0};
            debug_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value_q <= '0;
            debug_q <= '0;
        end else begin
            value_q <= value_d;
            debug_q <= debug_d;
        end
    end

    assign value = value_q;
    assign debug = debug_q;

endmodule

// File: tb/tb_floating_divide.sv
// tb/tb_floating_divide.sv - self-checking bench for floating_divide
module tb_floating_divide;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] value;
    logic [31:0] debug;

    int n_vec = 0;
    int n_bad = 0;

    floating_divide dut (
        .a     (a),
        .b     (b),
        .value (value),
        .debug (debug),
        .clk   (clk),
        .rst_n (rst_n)
    );

    always #5 clk = ~clk;

    function automatic bit is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 0);
    endfunction
    function automatic bit is_inf(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] == 0);
    endfunction
    function automatic bit is_zero(input logic [31:0] x);
        return x[30:23] == 8'h00;
    endfunction
    function automatic bit is_special(input logic [31:0] x, input logic [31:0] y);
        return is_nan(x) || is_nan(y) || is_inf(x) || is_inf(y) || is_zero(x) || is_zero(y);
    endfunction

    // Quotient from exact integer division of the significands.
    function automatic logic [31:0] m_value(input logic [31:0] x, input logic [31:0] y);
        logic s;
        longint unsigned ma, mb, qm, r;
        int e;
        s = x[31] ^ y[31];
        if (is_nan(x) || is_nan(y) || (is_zero(x) && is_zero(y)) || (is_inf(x) && is_inf(y)))
            return 32'h7FC00000;
        if (is_inf(x)) return {s, 31'h7F800000};
        if (is_inf(y)) return {s, 31'd0};
        if (is_zero(y)) return {s, 31'h7F800000};
        if (is_zero(x)) return {s, 31'd0};
        ma = 64'h800000 + 64'(x[22:0]);
        mb = 64'h800000 + 64'(y[22:0]);
        if (ma >= mb) begin
            qm = (ma << 23) / mb;
            r  = (ma << 23) % mb;
            e  = int'(x[30:23]) - int'(y[30:23]) + 127;
        end else begin
            qm = (ma << 24) / mb;
            r  = (ma << 24) % mb;
            e  = int'(x[30:23]) - int'(y[30:23]) + 126;
        end
        if ((2 * r > mb) || ((2 * r == mb) && (qm % 2 == 1))) qm = qm + 1;
        if (qm == 64'h1000000) begin
            qm = qm >> 1;
            e  = e + 1;
        end
        if (e <= 0) return {s, 31'd0};
        if (e >= 255) return {s, 31'h7F800000};
        return {s, 8'(e), 23'(qm)};
    endfunction

    function automatic logic [31:0] m_debug(input logic [31:0] x, input logic [31:0] y);
        longint unsigned ma, mb;
        if (is_special(x, y)) return 32'd0;
        ma = 64'h800000 + 64'(x[22:0]);
        mb = 64'h800000 + 64'(y[22:0]);
        return 32'((ma << 25) / mb);
    endfunction

    // Continuous check: expectation formed from the inputs seen at each edge.
    logic [31:0] exp_v, exp_d;
    bit          armed = 1'b0;

    always @(posedge clk) begin
        exp_v <= rst_n ? m_value(a, b) : 32'd0;
        exp_d <= rst_n ? m_debug(a, b) : 32'd0;
        armed <= 1'b1;
    end

    always @(negedge clk) begin
        if (armed) begin
            n_vec++;
            if (value !== exp_v) begin
                n_bad++;
                $display("FAIL cyc_value a=%08h b=%08h got %08h want %08h", a, b, value, exp_v);
            end
            n_vec++;
            if (debug !== exp_d) begin
                n_bad++;
                $display("FAIL cyc_debug a=%08h b=%08h got %08h want %08h", a, b, debug, exp_d);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got %08h want %08h", name, got, want);
        end
    endtask

    // Drive one vector, let one edge register it, then check DUT and model.
    task automatic apply(input string name, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] want);
        @(negedge clk);
        a = x;
        b = y;
        @(posedge clk);
        #1;
        check({name, "_dut"}, value, want);
        check({name, "_model"}, m_value(x, y), want);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        a     = 32'h3F80_0000;
        b     = 32'h4040_0000;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_value", value, 32'd0);
        check("reset_debug", debug, 32'd0);

        // Release reset with 1000 / -10 already applied.
        @(negedge clk);
        rst_n = 1'b1;
        a     = 32'h447A_0000;
        b     = 32'hC120_0000;
        @(posedge clk);
        #1;
        check("first_value", value, 32'hC2C8_0000);
        check("first_debug", debug, 32'h0320_0000);

        apply("same_32", 32'h4200_0000, 32'h4200_0000, 32'h3F80_0000);
        check("same_32_debug", debug, 32'h0200_0000);
        apply("one_third", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB);
        check("one_third_debug", debug, 32'h0155_5555);
        apply("two_thirds", 32'h4000_0000, 32'h4040_0000, 32'h3F2A_AAAB);
        apply("three_by_one", 32'h4040_0000, 32'h3F80_0000, 32'h4040_0000);
        apply("one_by_zero", 32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000);
        check("one_by_zero_debug", debug, 32'd0);
        apply("zero_by_zero", 32'h8000_0000, 32'h0000_0000, 32'h7FC0_0000);
        apply("inf_by_neg1", 32'h7F80_0000, 32'hBF80_0000, 32'hFF80_0000);
        apply("inf_by_inf", 32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000);
        apply("nan_in", 32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000);
        apply("one_by_inf", 32'h3F80_0000, 32'h7F80_0000, 32'h0000_0000);
        apply("neg1_by_neginf", 32'hBF80_0000, 32'hFF80_0000, 32'h0000_0000);
        apply("zero_by_two", 32'h0000_0000, 32'h4000_0000, 32'h0000_0000);
        apply("negzero_by_two", 32'h8000_0000, 32'h4000_0000, 32'h8000_0000);
        apply("denorm_num", 32'h0000_0001, 32'h3F80_0000, 32'h0000_0000);
        apply("denorm_den", 32'h3F80_0000, 32'h0000_0001, 32'h7F80_0000);
        apply("overflow", 32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000);
        apply("underflow", 32'h0080_0000, 32'h4000_0000, 32'h0000_0000);

        // Mid-stream reset with inputs held.
        apply("pre_reset", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_value", value, 32'd0);
        check("midreset_debug", debug, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_value", value, 32'h3EAA_AAAB);
        check("post_reset_debug", debug, 32'h0155_5555);

        // Back-to-back varied operands, checked by the per-cycle model.
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            a = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 160)), 23'($urandom)};
            b = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 160)), 23'($urandom)};
        end
        @(negedge clk);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/floating_divide.md
FLOATING_DIVIDE -- requirements
Module: floating_divide

Interface
REQ-001 Parameters: none; all widths fixed at IEEE-754 binary32.
REQ-002 clk  input  1  rising-edge clock; sole clock domain.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 a  input  32  dividend, IEEE-754 single (sign[31], exp[30:23], frac[22:0]).
REQ-005 b  input  32  divisor, IEEE-754 single.
REQ-006 value  output  32  registered quotient a/b, IEEE-754 single.
REQ-007 debug  output  32  registered diagnostic word, layout per REQ-017.
REQ-008 Port order on instantiation SHALL be a, b, value, debug, clk, rst_n.

Function
REQ-009 No handshake: the block SHALL sample a and b on every rising clk and register the result, with latency exactly 1 cycle.
REQ-010 Sign SHALL be a[31] XOR b[31] for all non-NaN results, including zero and infinity.
REQ-011 Normal operands: mantissas SHALL have the hidden 1 restored (24 bits), with a combinational restoring divide producing 24 quotient bits plus guard, round and sticky bits.
REQ-012 Exponent SHALL be ea - eb + 127, minus 1 when ma < mb (normalization shift); use at least 10-bit signed intermediate arithmetic.
REQ-013 Rounding SHALL be round-to-nearest-even; a mantissa carry-out from rounding SHALL increment the exponent.
REQ-014 Denormal inputs (exp=0, frac!=0) SHALL be treated as zero; any result with final exponent <= 0 SHALL flush to signed zero.
REQ-015 A final exponent >= 255 SHALL produce signed infinity (exp=0xFF, frac=0).
REQ-016 Special cases, by priority:
- either operand NaN, 0/0, or inf/inf -> 0x7FC00000
- inf/finite -> signed inf
- finite/inf -> signed zero
- nonzero/0 -> signed inf
- 0/nonzero -> signed zero
REQ-017 debug SHALL be registered with value:
- debug[25:0] = raw quotient bits (before normalization and rounding)
- debug[31:26] = 0
- debug = 0 whenever a special case of REQ-016 applies.
REQ-018 Changing inputs every cycle SHALL yield one independent result per cycle; no internal state other than the output registers.

Reset
REQ-019 When rst_n is low at a rising clk, value and debug SHALL become 0x00000000 on that edge, overriding any computed result.
REQ-020 After rst_n returns high, the first rising edge SHALL register the result for the current a and b.
REQ-021 Reset asserted mid-stream SHALL discard the in-flight result; no stale value SHALL appear afterward.

Structure
REQ-022 A shared package SHALL hold the field-width constants (EXP_W=8, FRAC_W=23, BIAS=127), the canonical NaN (0x7FC00000) and inf (0x7F800000) encodings, and the unpacked-float typedef {sign, exp, frac}.
REQ-023 The block SHALL contain one sub-module, fp_mant_div: a combinational 24-bit restoring divider returning the quotient and a sticky bit. Unpack, special-case, normalize and round logic SHALL reside in floating_divide.

Verification
REQ-024 Release rst_n, then drive a=0x447A0000 (1000), b=0xC1200000 (-10) -> value=0xC2C80000 (-100) after the first rising edge; the bench finishes within 2 cycles.
REQ-025 a=0x42000000, b=0x42000000 -> 0x3F800000; a=0x3F800000, b=0x40400000 -> 0x3EAAAAAB, which checks RNE.
REQ-026 Special cases:
- a=0x3F800000, b=0x00000000 -> 0x7F800000
- a=0x80000000, b=0x00000000 -> 0x7FC00000
- a=0x7F800000, b=0xBF800000 -> 0xFF800000
REQ-027 Range limits:
- a=0x7F000000, b=0x3E800000 -> 0x7F800000 (overflow)
- a=0x00800000, b=0x40000000 -> 0x00000000 (flush to zero)
REQ-028 Reset: hold valid inputs, assert rst_n low for one edge -> value=0, debug=0 on that edge; the next edge restores the correct quotient.
